// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU definitions: opcodes, IR field positions, control states
package cpu_pkg;

    // IR field positions; imm occupies [18:0] and overlaps Rc.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [4:0] OP_LD        = 5'b00000;
    localparam logic [4:0] OP_ST        = 5'b00010;
    localparam logic [4:0] OP_ADD       = 5'b00011;
    localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
    localparam logic [4:0] OP_ALU_LAST  = 5'b01100;
    localparam logic [4:0] OP_MUL       = 5'b01111;
    localparam logic [4:0] OP_DIV       = 5'b10000;
    localparam logic [4:0] OP_NOP       = 5'b11010;
    localparam logic [4:0] OP_HALT      = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } cu_state_e;

    typedef enum logic [2:0] {
        C_ALU, C_LD, C_ST, C_MULDIV, C_NOP, C_HALT, C_ILLEGAL
    } op_class_e;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational IR decode into instruction class and one-hot register selects
// Ports: ir (instruction register value) in; op_class, opcode, ra_oh/rb_oh/rc_oh out.
// CU_MULDIV_EN: when defined, mul/div decode as C_MULDIV; otherwise they are C_ILLEGAL.
module cu_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output op_class_e   op_class,
    output logic [4:0]  opcode,
    output logic [15:0] ra_oh,
    output logic [15:0] rb_oh,
    output logic [15:0] rc_oh
);

    // Low immediate bits feed only the datapath sign-extender, not control.
    logic unused_imm;
    assign unused_imm = ^ir[RC_LSB-1:0];

    always_comb begin
        opcode = ir[OPC_MSB:OPC_LSB];
        ra_oh  = onehot16(ir[RA_MSB:RA_LSB]);
        rb_oh  = onehot16(ir[RB_MSB:RB_LSB]);
        rc_oh  = onehot16(ir[RC_MSB:RC_LSB]);

        op_class = C_ILLEGAL;
        if (opcode == OP_LD) begin
            op_class = C_LD;
        end else if (opcode == OP_ST) begin
            op_class = C_ST;
        end else if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST) begin
            op_class = C_ALU;
        end else if (opcode == OP_NOP) begin
            op_class = C_NOP;
        end else if (opcode == OP_HALT) begin
            op_class = C_HALT;
`ifdef CU_MULDIV_EN
        end else if (opcode == OP_MUL || opcode == OP_DIV) begin
            op_class = C_MULDIV;
`endif
        end
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired control unit: fetch/decode/execute FSM and datapath strobes
// Ports: clk, clr (async active-low), run, IR, mem_rdy in; Rin/Rout one-hot register
// selects, PC/IR/MAR/MDR/Y/Z/HI/LO/C strobes, Read/Write, alu_op, halted, err out.
// CU_MULDIV_EN: when defined, mul/div drive LOin/HIin; otherwise LOin/HIin are tied low.
module control_unit
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        mem_rdy,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        PCout,
    output logic        incPC,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLowOut,
    output logic        ZHighOut,
    output logic        HIin,
    output logic        LOin,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        halted,
    output logic        err
);

    localparam int            CW        = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);
    localparam logic [15:0]   RIN_MASK  = 16'hFFFE;  // R0 is hardwired, never loaded

    op_class_e   op_class;
    logic [4:0]  opcode;
    logic [15:0] ra_oh, rb_oh, rc_oh;

    cu_decode u_decode (
        .ir       (IR),
        .op_class (op_class),
        .opcode   (opcode),
        .ra_oh    (ra_oh),
        .rb_oh    (rb_oh),
        .rc_oh    (rc_oh)
    );

    cu_state_e     state_q, state_d, done_state;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          armed_q, armed_d;
    logic          waiting;

    // Next-state logic. armed_q delays the first fetch by one edge after reset release.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        err_d      = err_q;
        armed_d    = 1'b1;
        done_state = run ? S_T0 : S_IDLE;
        waiting    = (state_q == S_T1) ||
                     (state_q == S_T6 && op_class == C_LD) ||
                     (state_q == S_T7 && op_class == C_ST);

        case (state_q)
            S_IDLE: if (run && armed_q) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_rdy) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                case (op_class)
                    C_ALU, C_LD, C_ST, C_MULDIV: state_d = S_T4;
                    C_NOP:   state_d = done_state;
                    C_HALT:  state_d = S_HALT;
                    default: begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (op_class == C_ALU) ? done_state : S_T6;
            S_T6: begin
                if (op_class == C_ST || (op_class == C_LD && mem_rdy)) state_d = S_T7;
                else if (op_class != C_LD) state_d = done_state;
            end
            S_T7:   if (op_class != C_ST || mem_rdy) state_d = done_state;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Counter is zero whenever a wait state is entered; it counts missed mem_rdy cycles.
        if (waiting && !mem_rdy) begin
            if (cnt_q == WAIT_LAST) begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            armed_q <= armed_d;
        end
    end

    assign halted = (state_q == S_HALT);
    assign err    = err_q;

    // Strobes decode from state_q because T3 must see the IR value latched at the end of T2.
    always_comb begin
        Rin = '0;  Rout = '0;  alu_op = '0;
        PCin = 1'b0;  PCout = 1'b0;  incPC = 1'b0;  IRin = 1'b0;
        MARin = 1'b0; MDRin = 1'b0;  MDRout = 1'b0; Yin = 1'b0;
        Zin = 1'b0;   ZLowOut = 1'b0; ZHighOut = 1'b0; Cout = 1'b0;
        Read = 1'b0;  Write = 1'b0;
`ifdef CU_MULDIV_EN
        HIin = 1'b0;  LOin = 1'b0;
`endif
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1; end
            S_T1: begin ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (op_class)
                    C_ALU, C_LD, C_ST: begin Rout = rb_oh; Yin = 1'b1; end
`ifdef CU_MULDIV_EN
                    C_MULDIV: begin Rout = ra_oh; Yin = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_ALU:       begin Rout = rc_oh; Zin = 1'b1; alu_op = opcode; end
                    C_LD, C_ST:  begin Cout = 1'b1;  Zin = 1'b1; alu_op = OP_ADD; end
`ifdef CU_MULDIV_EN
                    C_MULDIV:    begin Rout = rb_oh; Zin = 1'b1; alu_op = opcode; end
`endif
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    C_ALU:      begin ZLowOut = 1'b1; Rin = ra_oh & RIN_MASK; end
                    C_LD, C_ST: begin ZLowOut = 1'b1; MARin = 1'b1; end
`ifdef CU_MULDIV_EN
                    C_MULDIV:   begin ZLowOut = 1'b1; LOin = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_class)
                    C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
                    C_ST:     begin Rout = ra_oh; MDRin = 1'b1; end
`ifdef CU_MULDIV_EN
                    C_MULDIV: begin ZHighOut = 1'b1; HIin = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_class)
                    C_LD:    begin MDRout = 1'b1; Rin = ra_oh & RIN_MASK; end
                    C_ST:    Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

`ifndef CU_MULDIV_EN
    assign HIin = 1'b0;
    assign LOin = 1'b0;
`endif

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15, memory-handshake cycles before timeout halt.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 clr  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  high lets the FSM leave IDLE and start a fetch.
REQ-005 IR  input  32  instruction: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15], imm[18:0].
REQ-006 mem_rdy  input  1  memory done; completes a Read or Write cycle.
REQ-007 Rin, Rout  output  16 each  one-hot register load/drive selects, R0..R15.
REQ-008 PCin, PCout, incPC, IRin, MARin, MDRin, MDRout, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, Cout  output  1 each  datapath strobes.
REQ-009 Read, Write  output  1 each  memory request strobes.
REQ-010 alu_op  output  5  ALU opcode for the Zin cycle.
REQ-011 halted, err  output  1 each  halt status and error (illegal opcode or timeout).

Function
REQ-012 FSM states: IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT; one state per clock unless stalled on mem_rdy.
REQ-013 IDLE->T0 when run=1; otherwise IDLE holds with all strobes 0.
REQ-014 T0: PCout, MARin, incPC, Zin. T1: ZLowOut, PCin, Read, MDRin; holds until mem_rdy=1. T2: MDRout, IRin. T3 begins decode of the IR value latched in T2.
REQ-015 ALU ops (opcodes 00011..01100): T3 Rout[Rb], Yin; T4 Rout[Rc], Zin, alu_op=opcode; T5 ZLowOut, Rin[Ra]; next T0.
REQ-016 ld (00000): T3 Rout[Rb], Yin; T4 Cout, Zin, alu_op=ADD; T5 ZLowOut, MARin; T6 Read, MDRin, held until mem_rdy; T7 MDRout, Rin[Ra]; next T0.
REQ-017 st (00010): T3..T5 same as ld; T6 Rout[Ra], MDRin; T7 Write, held until mem_rdy; next T0.
REQ-018 nop (11010): T3 -> T0 with no strobes; halt (11011): T3 -> HALT.
REQ-019 Rin[0] is never asserted; a write to Ra=0 is discarded.
REQ-020 At most one Rout bit and at most one bus driver (Rout, PCout, MDRout, ZLowOut, ZHighOut, Cout) are active in any cycle.
REQ-021 Stall counter resets on entry to T1/T6/T7; if mem_rdy is not seen within MEM_WAIT_MAX cycles: err=1, HALT.
REQ-022 mem_rdy arriving in the first stall cycle completes the access in that cycle (latency 1).
REQ-023 Undefined opcode at T3: err=1, HALT.
REQ-024 HALT: all strobes 0, halted=1; exit only by reset; run is ignored.
REQ-025 Dropping run mid-instruction finishes the instruction, then returns to IDLE at the T0 boundary.

Reset
REQ-026 clr=0 immediately forces IDLE, clears all strobes, alu_op=0, halted=0, err=0 and the stall counter, even mid-instruction or mid-memory-access.
REQ-027 The first fetch happens no earlier than the second rising edge after clr is released.

Configuration
REQ-028 CU_MULDIV_EN defined: mul (01111)/div (10000) run T3 Rout[Ra], Yin; T4 Rout[Rb], Zin, alu_op=opcode; T5 ZLowOut, LOin; T6 ZHighOut, HIin; next T0.
REQ-029 CU_MULDIV_EN undefined: mul/div are undefined opcodes (REQ-023); no HIin/LOin logic is built, and both are tied to 0.

Structure
REQ-030 Shared package cpu_pkg holds the opcode constants, IR field positions and the state enum; the datapath uses the same package.
REQ-031 Sub-module cu_decode (combinational: IR -> class, Ra/Rb/Rc one-hot) is instantiated once; FSM and strobe generation stay in control_unit.

Verification
REQ-032 Reset then run=1, mem_rdy=1 every cycle, IR=add R3,R1,R2 (opcode 00011): T0..T5 strobes per REQ-014/015; Rin=0x0008 in T5; 6 cycles per instruction.
REQ-033 ld R5 with Rb=R2, imm=0x10, mem_rdy delayed 3 cycles in T6: T6 held 4 cycles, then MDRout and Rin=0x0020 in T7.
REQ-034 st with mem_rdy never asserted: Write held MEM_WAIT_MAX cycles, then err=1, halted=1, all strobes 0.
REQ-035 IR=add R0,R1,R2: Rin stays 0x0000 for the whole instruction; opcode 11111: err=1, HALT at T3.
REQ-036 clr pulsed low during T6 of ld: all strobes drop asynchronously, state IDLE; re-run fetches from the current PC.
REQ-037 With and without CU_MULDIV_EN, IR=mul R4,R5: LOin at T5 and HIin at T6 when defined; err=1 and HALT at T3 when undefined.
